// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the shared single-ported memory between instruction
// fetch and data LD/ST. Data wins by default; a saturating streak counter
// hands the port to fetch after MAX_DM_STREAK consecutive data grants that
// were taken while fetch waited. A watchdog traps a memory that never answers.
module mem_arbiter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        if_done,
  output logic [15:0] if_data,
  output logic        dm_done,
  output logic [15:0] dm_data,
  output logic        if_stall,
  output logic        dm_stall,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_IF, ISSUE_DM, WAIT_IF, WAIT_DM, ERR
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

  state_t      state;
  logic [3:0]  streak;
  logic [7:0]  tmoCnt;
  logic [7:0]  tmoNext;
  logic [15:0] ifDataQ;
  logic [15:0] dmDataQ;
  logic        errQ;
  logic        dmReq;
  logic        protoErr;
  logic        grantDm;
  logic        grantIf;
  logic        inIssue;

  assign dmReq   = dm_rd | dm_wr;
  assign inIssue = (state == ISSUE_IF) | (state == ISSUE_DM);
  // A done before the access is even waiting, or a read+write at once, is a
  // broken requester/memory; trap it rather than guess.
  assign protoErr = (dm_rd & dm_wr) | (mem_done & ((state == IDLE) | inIssue));
  assign tmoNext  = tmoCnt + 8'd1;

  // Data wins unless fetch has already been passed over MAX_DM_STREAK times.
  assign grantDm = (state == IDLE) & dmReq & ~(if_req & (streak == STREAK_MAX));
  assign grantIf = (state == IDLE) & if_req & ~grantDm;

  // Completion is reported in the very cycle memory answers.
  assign if_done  = (state == WAIT_IF) & mem_done;
  assign dm_done  = (state == WAIT_DM) & mem_done;
  assign if_data  = if_done ? mem_rdata : ifDataQ;
  assign dm_data  = (dm_done & ~mem_wr) ? mem_rdata : dmDataQ;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dmReq & ~dm_done;
  assign err      = errQ;

  // Arbitration FSM with registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= 4'd0;
      tmoCnt    <= 8'd0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      errQ      <= 1'b0;
    end else if (state != ERR && protoErr) begin
      state  <= ERR;
      errQ   <= 1'b1;
      mem_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantDm) begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wr    <= dm_wr;
            mem_en    <= 1'b1;
            // Only streaks taken while fetch waits count against fetch.
            if (!if_req)                streak <= 4'd0;
            else if (streak != STREAK_MAX) streak <= streak + 4'd1;
            state <= ISSUE_DM;
          end else if (grantIf) begin
            mem_addr <= if_addr;
            mem_wr   <= 1'b0;
            mem_en   <= 1'b1;
            streak   <= 4'd0;
            state    <= ISSUE_IF;
          end
        end
        ISSUE_IF, ISSUE_DM: begin
          mem_en <= 1'b0;
          tmoCnt <= 8'd0;
          state  <= (state == ISSUE_IF) ? WAIT_IF : WAIT_DM;
        end
        WAIT_IF, WAIT_DM: begin
          if (mem_done) begin
            state <= IDLE;
          end else begin
            tmoCnt <= tmoNext;
            if (tmoNext == TMO_LIM) begin
              state <= ERR;
              errQ  <= 1'b1;
            end
          end
        end
        ERR: begin
          mem_en <= 1'b0;
          errQ   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returned data holds between done pulses; stores never touch load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifDataQ <= 16'h0000;
      dmDataQ <= 16'h0000;
    end else begin
      if (if_done)           ifDataQ <= mem_rdata;
      if (dm_done & ~mem_wr) dmDataQ <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default MAX_DM_STREAK=4, TIMEOUT=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
// later, mid-cycle.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_rd, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_en, mem_wr, if_done, dm_done, if_stall, dm_stall, err;
  logic [15:0] mem_addr, mem_wdata, if_data, dm_data;

  int nAssert = 0;
  int nFail   = 0;

  logic [15:0] expG [6] = '{16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0030, 16'h0300};
  int  g;
  logic pend;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_done(if_done), .if_data(if_data), .dm_done(dm_done), .dm_data(dm_data),
    .if_stall(if_stall), .dm_stall(dm_stall), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; dm_rd = 0; dm_wr = 0; mem_done = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    tick(); tick();
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_if_done", if_done, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_if_data", if_data, 16'h0000);
    rst = 1'b0;

    // single fetch, memory answers two cycles after mem_en
    tick(); if_req = 1; if_addr = 16'h0010; #2;
    chk1("f0_stall", if_stall, 1'b1);
    chk1("f0_mem_en", mem_en, 1'b0);
    tick(); #2;
    chk1("f1_mem_en", mem_en, 1'b1);
    chk("f1_mem_addr", mem_addr, 16'h0010);
    chk1("f1_mem_wr", mem_wr, 1'b0);
    tick(); #2;
    chk1("f2_mem_en", mem_en, 1'b0);
    chk1("f2_if_done", if_done, 1'b0);
    tick(); mem_done = 1; mem_rdata = 16'hA5A5; #2;
    chk1("f3_if_done", if_done, 1'b1);
    chk("f3_if_data", if_data, 16'hA5A5);
    chk1("f3_stall", if_stall, 1'b0);
    tick(); mem_done = 0; if_req = 0; mem_rdata = 16'h0000; #2;
    chk1("f4_if_done", if_done, 1'b0);
    chk("f4_if_hold", if_data, 16'hA5A5);

    // store
    tick(); dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'h1234; #2;
    tick(); #2;
    chk1("s1_mem_en", mem_en, 1'b1);
    chk1("s1_mem_wr", mem_wr, 1'b1);
    chk("s1_mem_addr", mem_addr, 16'h0100);
    chk("s1_mem_wdata", mem_wdata, 16'h1234);
    chk1("s1_dm_stall", dm_stall, 1'b1);
    tick(); mem_done = 1; #2;
    chk1("s2_dm_done", dm_done, 1'b1);
    chk1("s2_dm_stall", dm_stall, 1'b0);
    chk1("s2_if_done", if_done, 1'b0);
    tick(); mem_done = 0; dm_wr = 0; #2;
    chk1("s3_dm_done", dm_done, 1'b0);
    chk1("s3_err", err, 1'b0);

    // simultaneous: data first, fetch at the next IDLE
    tick(); dm_rd = 1; if_req = 1; dm_addr = 16'h0200; if_addr = 16'h0020; #2;
    tick(); #2;
    chk1("sim1_mem_en", mem_en, 1'b1);
    chk("sim1_addr", mem_addr, 16'h0200);
    chk1("sim1_if_stall", if_stall, 1'b1);
    tick(); mem_done = 1; mem_rdata = 16'hBEEF; #2;
    chk1("sim2_dm_done", dm_done, 1'b1);
    chk("sim2_dm_data", dm_data, 16'hBEEF);
    chk1("sim2_if_stall", if_stall, 1'b1);
    tick(); mem_done = 0; dm_rd = 0; #2;
    chk1("sim3_mem_en", mem_en, 1'b0);
    chk1("sim3_if_stall", if_stall, 1'b1);
    tick(); #2;
    chk1("sim4_mem_en", mem_en, 1'b1);
    chk("sim4_addr", mem_addr, 16'h0020);
    tick(); mem_done = 1; mem_rdata = 16'h1111; #2;
    chk1("sim5_if_done", if_done, 1'b1);
    chk("sim5_if_data", if_data, 16'h1111);
    tick(); mem_done = 0; if_req = 0; #2;

    // starvation: both held; expect D D D D I D
    if_req = 1; if_addr = 16'h0030; dm_rd = 1; dm_addr = 16'h0300;
    g = 0; pend = 0;
    for (int c = 0; c < 17; c++) begin
      tick(); mem_done = pend; mem_rdata = 16'(c); pend = 0; #2;
      if (mem_en) begin
        if (g < 6) chk($sformatf("starve_grant%0d", g), mem_addr, expG[g]);
        g++;
        pend = 1;
      end
    end
    chk("starve_count", 16'(g), 16'd6);
    tick(); mem_done = 0; dm_rd = 0; if_req = 0; #2;
    chk1("starve_err", err, 1'b0);

    // reset during WAIT_DM, then a late mem_done in IDLE
    tick(); dm_rd = 1; dm_addr = 16'h0500; #2;
    tick(); #2;
    chk1("rw1_mem_en", mem_en, 1'b1);
    tick(); #2;
    rst = 1; #1;
    chk1("rw_mem_en", mem_en, 1'b0);
    chk1("rw_mem_wr", mem_wr, 1'b0);
    chk("rw_mem_addr", mem_addr, 16'h0000);
    chk("rw_mem_wdata", mem_wdata, 16'h0000);
    chk("rw_dm_data", dm_data, 16'h0000);
    chk1("rw_err", err, 1'b0);
    tick(); dm_rd = 0; rst = 0;
    tick(); mem_done = 1; #2;
    chk1("late_err_pre", err, 1'b0);
    tick(); mem_done = 0; #2;
    chk1("late_err", err, 1'b1);
    chk1("late_dm_done", dm_done, 1'b0);
    doReset(); #2;
    chk1("late_rst_err", err, 1'b0);

    // watchdog: mem_en in cycle 1, err in cycle 18
    if_req = 1; if_addr = 16'h0040;
    tick(); #2;
    chk1("wd1_mem_en", mem_en, 1'b1);
    for (int c = 2; c <= 17; c++) begin
      tick(); #2;
      chk1($sformatf("wd%0d_err", c), err, 1'b0);
    end
    tick(); #2;
    chk1("wd18_err", err, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      chk1("wd_no_mem_en", mem_en, 1'b0);
      chk1("wd_if_stall", if_stall, 1'b1);
      chk1("wd_sticky", err, 1'b1);
    end
    if_req = 0;
    doReset(); #2;
    chk1("wd_rst_err", err, 1'b0);

    // both data strobes high
    tick(); dm_rd = 1; dm_wr = 1; dm_addr = 16'h0600; #2;
    tick(); #2;
    chk1("dual_err", err, 1'b1);
    chk1("dual_mem_en", mem_en, 1'b0);
    chk1("dual_dm_stall", dm_stall, 1'b1);
    dm_rd = 0; dm_wr = 0;
    doReset(); #2;
    chk1("dual_rst_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
